sequenciador_servos: RTL and testbench

Micro-sequencer that converts one 3-bit cube-move code into a timed sequence of servo set-points for the Rubik's Polibot base, lid (tampa) and flipper (peteleco). It sits between the main control unit, which issues one move at a time from the solution list, and the three PWM servo generators in the datapath. Each set-point is held for a parameterised settle time before the next step. The block also tracks the base angle across moves and rejects moves that would drive the base out of range.

---
 rtl/sequenciador_servos_if.sv | 23 ++
 rtl/sequenciador_servos.sv | 128 ++++++++++++
 tb/tb_sequenciador_servos.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sequenciador_servos_if.sv
// Move-request handshake and servo set-point bundle between the control unit
// and the servo micro-sequencer.
interface sequenciador_servos_if;
    logic       iniciar_mov;
    logic [2:0] movimento;
    logic [1:0] pos_base;
    logic       pos_tampa;
    logic       pos_peteleco;
    logic       ocupado;
    logic       fim_mov;
    logic       erro_mov;
    logic [3:0] db_estado;

    modport master (
        output iniciar_mov, movimento,
        input  pos_base, pos_tampa, pos_peteleco, ocupado, fim_mov, erro_mov, db_estado
    );

    modport slave (
        input  iniciar_mov, movimento,
        output pos_base, pos_tampa, pos_peteleco, ocupado, fim_mov, erro_mov, db_estado
    );
endinterface

// File: rtl/sequenciador_servos.sv
// Turns one 3-bit cube move into a timed sequence of base/lid/flipper servo
// set-points, tracking the base angle and rejecting out-of-range moves.
module sequenciador_servos #(
    parameter int T_BASE     = 25_000_000,
    parameter int T_TAMPA    = 15_000_000,
    parameter int T_PETELECO = 10_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    sequenciador_servos_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        DESCE_TAMPA = 4'd1,
        GIRA_BASE   = 4'd2,
        SOBE_TAMPA  = 4'd3,
        EMPURRA     = 4'd4,
        RECUA       = 4'd5,
        FIM         = 4'd6,
        ERRO        = 4'd7
    } estado_t;

    localparam logic [24:0] LIM_BASE  = 25'(T_BASE - 1);
    localparam logic [24:0] LIM_TAMPA = 25'(T_TAMPA - 1);
    localparam logic [24:0] LIM_PET   = 25'(T_PETELECO - 1);

    estado_t     state, state_nx;
    logic [24:0] cnt, cnt_nx;
    logic [2:0]  mov_q, mov_nx, mov_sel;
    logic [1:0]  base_q, base_nx;
    logic        tampa_q, tampa_nx;
    logic        pet_q, pet_nx;
    logic        valido;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            mov_q   <= '0;
            base_q  <= '0;
            tampa_q <= 1'b0;
            pet_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            mov_q   <= mov_nx;
            base_q  <= base_nx;
            tampa_q <= tampa_nx;
            pet_q   <= pet_nx;
        end
    end

    // The GIRA_BASE entry from IDLE happens on the accept edge, before mov_q is loaded.
    assign mov_sel = (state == IDLE) ? bus.movimento : mov_q;

    always_comb begin
        valido = 1'b1;
        case (bus.movimento)
            3'd1, 3'd3: valido = (base_q < 2'd2);
            3'd2, 3'd4: valido = (base_q > 2'd0);
            3'd7:       valido = 1'b0;
            default:    valido = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        mov_nx   = mov_q;
        base_nx  = base_q;
        tampa_nx = tampa_q;
        pet_nx   = pet_q;
        cnt_nx   = '0;

        case (state)
            IDLE: begin
                if (bus.iniciar_mov) begin
                    mov_nx = bus.movimento;
                    if (!valido) state_nx = ERRO;
                    else begin
                        case (bus.movimento)
                            3'd0:       state_nx = FIM;
                            3'd3, 3'd4: state_nx = DESCE_TAMPA;
                            3'd5:       state_nx = EMPURRA;
                            default:    state_nx = GIRA_BASE;
                        endcase
                    end
                end
            end
            DESCE_TAMPA: if (cnt == LIM_TAMPA) state_nx = GIRA_BASE;
            GIRA_BASE: begin
                if (cnt == LIM_BASE)
                    state_nx = (mov_q == 3'd3 || mov_q == 3'd4) ? SOBE_TAMPA : FIM;
            end
            SOBE_TAMPA: if (cnt == LIM_TAMPA) state_nx = FIM;
            EMPURRA:    if (cnt == LIM_PET)   state_nx = RECUA;
            RECUA:      if (cnt == LIM_PET)   state_nx = FIM;
            default:    state_nx = IDLE;
        endcase

        // Set-points move only on entry; the dwell counter restarts on every entry.
        if (state_nx != state) begin
            case (state_nx)
                DESCE_TAMPA: tampa_nx = 1'b1;
                SOBE_TAMPA:  tampa_nx = 1'b0;
                EMPURRA:     pet_nx   = 1'b1;
                RECUA:       pet_nx   = 1'b0;
                GIRA_BASE: begin
                    case (mov_sel)
                        3'd1, 3'd3: base_nx = base_q + 2'd1;
                        3'd2, 3'd4: base_nx = base_q - 2'd1;
                        default:    base_nx = 2'd0;
                    endcase
                end
                default: ;
            endcase
        end else if (state != IDLE) begin
            cnt_nx = cnt + 25'd1;
        end
    end

    assign bus.pos_base     = base_q;
    assign bus.pos_tampa    = tampa_q;
    assign bus.pos_peteleco = pet_q;
    assign bus.ocupado      = (state != IDLE);
    assign bus.fim_mov      = (state == FIM);
    assign bus.erro_mov     = (state == ERRO);
    assign bus.db_estado    = state;
endmodule

// File: tb/tb_sequenciador_servos.sv
// Directed bench: each move pushes its expected per-cycle output trace into a
// scoreboard queue, which is popped and compared cycle by cycle.
module tb_sequenciador_servos;
    localparam int TB_B = 4;
    localparam int TB_T = 3;
    localparam int TB_P = 2;

    typedef struct packed {
        logic [3:0] est;
        logic [1:0] base;
        logic       tampa;
        logic       pet;
        logic       oc;
        logic       fim;
        logic       err;
    } snap_t;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [1:0] mb = 2'd0;
    snap_t q[$];

    sequenciador_servos_if bus();

    sequenciador_servos #(.T_BASE(TB_B), .T_TAMPA(TB_T), .T_PETELECO(TB_P)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic snap_t mk(logic [3:0] est, logic [1:0] b, logic t, logic p,
                                 logic f, logic e);
        snap_t s;
        s.est = est; s.base = b; s.tampa = t; s.pet = p;
        s.oc = (est != 4'd0); s.fim = f; s.err = e;
        return s;
    endfunction

    task automatic push_n(int n, logic [3:0] est, logic t, logic p);
        for (int i = 0; i < n; i++) q.push_back(mk(est, mb, t, p, 1'b0, 1'b0));
    endtask

    // Expected trace from cycle k+1 through the IDLE cycle after FIM/ERRO.
    task automatic push_move(logic [2:0] code);
        logic ok;
        case (code)
            3'd1, 3'd3: ok = (mb < 2'd2);
            3'd2, 3'd4: ok = (mb > 2'd0);
            3'd7:       ok = 1'b0;
            default:    ok = 1'b1;
        endcase
        if (!ok) begin
            q.push_back(mk(4'd7, mb, 1'b0, 1'b0, 1'b0, 1'b1));
        end else begin
            case (code)
                3'd1: begin mb = mb + 2'd1; push_n(TB_B, 4'd2, 1'b0, 1'b0); end
                3'd2: begin mb = mb - 2'd1; push_n(TB_B, 4'd2, 1'b0, 1'b0); end
                3'd3, 3'd4: begin
                    push_n(TB_T, 4'd1, 1'b1, 1'b0);
                    mb = (code == 3'd3) ? mb + 2'd1 : mb - 2'd1;
                    push_n(TB_B, 4'd2, 1'b1, 1'b0);
                    push_n(TB_T, 4'd3, 1'b0, 1'b0);
                end
                3'd5: begin
                    push_n(TB_P, 4'd4, 1'b0, 1'b1);
                    push_n(TB_P, 4'd5, 1'b0, 1'b0);
                end
                3'd6: begin mb = 2'd0; push_n(TB_B, 4'd2, 1'b0, 1'b0); end
                default: ;
            endcase
            q.push_back(mk(4'd6, mb, 1'b0, 1'b0, 1'b1, 1'b0));
        end
        q.push_back(mk(4'd0, mb, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    task automatic check_one(string tag);
        snap_t exp, got;
        exp = q.pop_front();
        got = '{est: bus.db_estado, base: bus.pos_base, tampa: bus.pos_tampa,
                pet: bus.pos_peteleco, oc: bus.ocupado, fim: bus.fim_mov, err: bus.erro_mov};
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d got est=%0d base=%0d tampa=%b pet=%b oc=%b fim=%b err=%b exp est=%0d base=%0d tampa=%b pet=%b oc=%b fim=%b err=%b",
                   tag, cyc, got.est, got.base, got.tampa, got.pet, got.oc, got.fim, got.err,
                   exp.est, exp.base, exp.tampa, exp.pet, exp.oc, exp.fim, exp.err);
        end
    endtask

    // Pops n entries, one per cycle at the falling edge; optionally re-requests
    // (code 1) during cycle k+poke_at to show busy requests are dropped.
    task automatic drain(string tag, int n, int poke_at);
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            bus.iniciar_mov = 1'b0;
            cyc = i;
            check_one(tag);
            if (i == poke_at) begin
                bus.iniciar_mov = 1'b1;
                bus.movimento   = 3'd1;
            end
        end
    endtask

    task automatic issue(string tag, logic [2:0] code, int poke_at);
        bus.iniciar_mov = 1'b1;
        bus.movimento   = code;
        push_move(code);
        drain(tag, q.size(), poke_at);
    endtask

    initial begin
        reset = 1'b1;
        bus.iniciar_mov = 1'b0;
        bus.movimento   = 3'd0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        cyc = 0;
        q.push_back(mk(4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        check_one("reset");
        reset = 1'b0;
        q.push_back(mk(4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        drain("post_reset", 1, 0);

        issue("rot_cw",       3'd1, 0);   // base 0 -> 1
        issue("layer_cw",     3'd3, 0);   // base 1 -> 2
        issue("rot_cw_limit", 3'd1, 0);   // rejected at 2
        issue("reserved",     3'd7, 0);
        issue("flip_busy",    3'd5, 2);   // extra request during EMPURRA ignored
        issue("home",         3'd6, 0);   // base 2 -> 0
        issue("nop",          3'd0, 0);
        issue("rot_ccw_lim",  3'd2, 0);   // rejected at 0
        issue("layer_ccw_lim",3'd4, 0);   // rejected at 0
        issue("rot_cw2",      3'd1, 0);
        issue("rot_ccw",      3'd2, 0);   // base 1 -> 0
        issue("rot_cw3",      3'd1, 0);
        issue("rot_cw4",      3'd1, 0);   // base 2
        issue("home_again",   3'd6, 0);
        issue("rot_cw5",      3'd1, 0);
        issue("rot_cw6",      3'd1, 0);   // base 2 again

        // Layer CCW aborted by reset sampled at edge k+5.
        bus.iniciar_mov = 1'b1;
        bus.movimento   = 3'd4;
        push_move(3'd4);
        drain("abort", 5, 0);
        reset = 1'b1;
        q.delete();
        mb = 2'd0;
        q.push_back(mk(4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        drain("abort_reset", 1, 0);
        reset = 1'b0;
        push_n(4, 4'd0, 1'b0, 1'b0);
        drain("abort_idle", 4, 0);

        issue("after_abort",  3'd1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
